// File: rtl/sram_word_controller.sv
// Word-wide CPU access to an asynchronous SRAM, split into SRAM-width beats,
// each stretched by WAIT_STATES extra cycles; ready stalls the pipeline meanwhile.
module sram_word_controller #(
  parameter int          DATA_W      = 32,
  parameter int          SRAM_DW     = 16,
  parameter int          SRAM_AW     = 18,
  parameter int          WAIT_STATES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic               rd_en,
  input  logic [31:0]        address,
  input  logic [DATA_W-1:0]  write_data,
  output logic [DATA_W-1:0]  read_data,
  output logic               ready,
  inout  wire  [SRAM_DW-1:0] SRAM_DQ,
  output logic [SRAM_AW-1:0] SRAM_ADDR,
  output logic               SRAM_WE_N,
  output logic               SRAM_UB_N,
  output logic               SRAM_LB_N,
  output logic               SRAM_CE_N,
  output logic               SRAM_OE_N
);

  localparam int BEATS = DATA_W / SRAM_DW;
  localparam int BOFF  = $clog2(DATA_W / 8);
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [BW-1:0]       beat_q, beat_d;
  logic [3:0]          wait_q, wait_d;
  logic [31:0]         word_q, word_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                is_wr_q, is_wr_d;
  logic [DATA_W-1:0]   read_data_q, read_data_d;
  logic                drive;
  int unsigned         lsb;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      beat_q      <= '0;
      wait_q      <= '0;
      word_q      <= '0;
      wdata_q     <= '0;
      is_wr_q     <= 1'b0;
      read_data_q <= '0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      wait_q      <= wait_d;
      word_q      <= word_d;
      wdata_q     <= wdata_d;
      is_wr_q     <= is_wr_d;
      read_data_q <= read_data_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    wait_d      = wait_q;
    word_d      = word_q;
    wdata_d     = wdata_q;
    is_wr_d     = is_wr_q;
    read_data_d = read_data_q;
    lsb         = 32'(beat_q) * SRAM_DW;
    case (state_q)
      IDLE: begin
        if (wr_en || rd_en) begin
          // Subtraction wraps on purpose: addresses below BASE_ADDR alias high SRAM words.
          word_d  = (address - BASE_ADDR) >> BOFF;
          wdata_d = write_data;
          is_wr_d = wr_en;
          beat_d  = '0;
          wait_d  = '0;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (wait_q == 4'(WAIT_STATES)) begin
          if (!is_wr_q) read_data_d[lsb +: SRAM_DW] = SRAM_DQ;
          if (beat_q == BW'(BEATS - 1)) begin
            state_d = DONE;
          end else begin
            beat_d = beat_q + 1'b1;
            wait_d = '0;
          end
        end else begin
          wait_d = wait_q + 4'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign drive     = (state_q == ACCESS) && is_wr_q;
  assign SRAM_DQ   = drive ? wdata_q[lsb +: SRAM_DW] : {SRAM_DW{1'bz}};
  assign SRAM_WE_N = !drive;
  assign SRAM_ADDR = (state_q == ACCESS) ? SRAM_AW'(word_q * 32'(BEATS) + 32'(beat_q)) : '0;
  assign ready     = ((state_q == IDLE) && !(rd_en || wr_en)) || (state_q == DONE);
  assign read_data = read_data_q;

  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;
  assign SRAM_CE_N = 1'b0;
  assign SRAM_OE_N = 1'b0;

endmodule

// File: tb/tb_sram_word_controller.sv
// Directed bench for sram_word_controller: vector table of word accesses plus
// hand-written reset-abort and zero-wait-state sequences.
module tb_sram_word_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en, rd_en;
  logic [31:0] address, write_data, read_data;
  logic        ready;
  wire  [15:0] sram_dq;
  logic [17:0] sram_addr;
  logic        we_n, ub_n, lb_n, ce_n, oe_n;

  logic        wr_en0, rd_en0;
  logic [31:0] address0, write_data0, read_data0;
  logic        ready0;
  wire  [15:0] sram_dq0;
  logic [17:0] sram_addr0;
  logic        we_n0, ub_n0, lb_n0, ce_n0, oe_n0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sram_word_controller dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .address(address),
    .write_data(write_data), .read_data(read_data), .ready(ready),
    .SRAM_DQ(sram_dq), .SRAM_ADDR(sram_addr), .SRAM_WE_N(we_n),
    .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n), .SRAM_CE_N(ce_n), .SRAM_OE_N(oe_n)
  );

  sram_word_controller #(.WAIT_STATES(0)) dut0 (
    .clk(clk), .rst(rst), .wr_en(wr_en0), .rd_en(rd_en0), .address(address0),
    .write_data(write_data0), .read_data(read_data0), .ready(ready0),
    .SRAM_DQ(sram_dq0), .SRAM_ADDR(sram_addr0), .SRAM_WE_N(we_n0),
    .SRAM_UB_N(ub_n0), .SRAM_LB_N(lb_n0), .SRAM_CE_N(ce_n0), .SRAM_OE_N(oe_n0)
  );

  // SRAM model: 16 words, indexed by the low 4 address bits (0x3FFFE/F land on 14/15).
  logic [15:0] mem [16];
  logic [15:0] mem_out;
  assign mem_out = mem[sram_addr[3:0]];
  assign sram_dq = (we_n && !ready) ? mem_out : 16'bz;
  always @(posedge clk) if (!we_n) mem[sram_addr[3:0]] <= sram_dq;

  assign sram_dq0 = (we_n0 && !ready0) ? {8'hC0, sram_addr0[7:0]} : 16'bz;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic run_req(input logic wr, input logic rd, input logic [31:0] a, input logic [31:0] d,
                         output int low, output logic [17:0] a0, output logic [17:0] a1,
                         output int we_lo);
    int cyc;
    bit done;
    @(negedge clk);
    wr_en = wr; rd_en = rd; address = a; write_data = d;
    #1 chk("ready_low_on_request", 64'(ready), 64'(0));
    cyc = 0; done = 0; we_lo = 0; a0 = '0; a1 = '0;
    while (!done && cyc < 20) begin
      @(negedge clk);
      if (ready) begin
        done = 1;
        chk("addr_zero_in_done", 64'(sram_addr), 64'(0));
        wr_en = 0; rd_en = 0;
      end else begin
        if (cyc == 0) a0 = sram_addr;
        if (cyc == 2) a1 = sram_addr;
        if (!we_n) we_lo++;
        cyc++;
      end
    end
    if (!done) chk("ready_timeout", 64'(0), 64'(1));
    low = cyc;
  endtask

  typedef struct {
    string       name;
    logic        wr;
    logic        rd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [17:0] a0;
    logic [17:0] a1;
    logic [31:0] rdata;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int low, we_lo, cyc;
    logic [17:0] a0, a1;
    bit done;

    vecs[0] = '{"rd_1024",    1'b0, 1'b1, 32'd1024, 32'h0,        18'h0,     18'h1,     32'hABCD1234};
    vecs[1] = '{"wr_1032",    1'b1, 1'b0, 32'd1032, 32'hDEADBEEF, 18'h4,     18'h5,     32'hABCD1234};
    vecs[2] = '{"rd_1032",    1'b0, 1'b1, 32'd1032, 32'h0,        18'h4,     18'h5,     32'hDEADBEEF};
    vecs[3] = '{"both_1028",  1'b1, 1'b1, 32'd1028, 32'h55AA00FF, 18'h2,     18'h3,     32'hDEADBEEF};
    vecs[4] = '{"rd_1020",    1'b0, 1'b1, 32'd1020, 32'h0,        18'h3FFFE, 18'h3FFFF, 32'h22221111};
    vecs[5] = '{"rd_1028",    1'b0, 1'b1, 32'd1028, 32'h0,        18'h2,     18'h3,     32'h55AA00FF};
    vecs[6] = '{"rd_1035",    1'b0, 1'b1, 32'd1035, 32'h0,        18'h4,     18'h5,     32'hDEADBEEF};

    for (int i = 0; i < 16; i++) mem[i] = 16'h0;
    mem[0] = 16'h1234; mem[1] = 16'hABCD; mem[14] = 16'h1111; mem[15] = 16'h2222;

    rst = 1; wr_en = 0; rd_en = 0; address = 0; write_data = 0;
    wr_en0 = 0; rd_en0 = 0; address0 = 0; write_data0 = 0;
    repeat (3) @(negedge clk);
    chk("reset_read_data", 64'(read_data), 64'(0));
    chk("reset_we_n", 64'(we_n), 64'(1));
    chk("reset_addr", 64'(sram_addr), 64'(0));
    chk("reset_ready_idle", 64'(ready), 64'(1));
    chk("reset_ties", 64'({ub_n, lb_n, ce_n, oe_n}), 64'(0));
    rd_en = 1;
    #1 chk("reset_ready_comb", 64'(ready), 64'(0));
    rd_en = 0;
    #1 chk("reset_ready_comb_release", 64'(ready), 64'(1));
    rst = 0;

    foreach (vecs[i]) begin
      run_req(vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].wdata, low, a0, a1, we_lo);
      chk({vecs[i].name, "_low_cycles"}, 64'(low), 64'(4));
      chk({vecs[i].name, "_beat0_addr"}, 64'(a0), 64'(vecs[i].a0));
      chk({vecs[i].name, "_beat1_addr"}, 64'(a1), 64'(vecs[i].a1));
      chk({vecs[i].name, "_we_low_cycles"}, 64'(we_lo), vecs[i].wr ? 64'(4) : 64'(0));
      chk({vecs[i].name, "_read_data"}, 64'(read_data), 64'(vecs[i].rdata));
      if (vecs[i].wr) begin
        chk({vecs[i].name, "_mem_lo"}, 64'(mem[vecs[i].a0[3:0]]), 64'(vecs[i].wdata[15:0]));
        chk({vecs[i].name, "_mem_hi"}, 64'(mem[vecs[i].a1[3:0]]), 64'(vecs[i].wdata[31:16]));
      end
    end

    // Zero wait states: one cycle per beat, ready high two cycles after the request edge.
    @(negedge clk);
    rd_en0 = 1; address0 = 32'd1024;
    cyc = 0; done = 0;
    while (!done && cyc < 20) begin
      @(negedge clk);
      if (ready0) begin
        done = 1;
        rd_en0 = 0;
      end else begin
        if (cyc == 0) chk("ws0_beat0_addr", 64'(sram_addr0), 64'(0));
        if (cyc == 1) chk("ws0_beat1_addr", 64'(sram_addr0), 64'(1));
        cyc++;
      end
    end
    if (!done) chk("ws0_timeout", 64'(0), 64'(1));
    chk("ws0_low_cycles", 64'(cyc), 64'(2));
    chk("ws0_read_data", 64'(read_data0), 64'(32'hC001C000));

    // Reset during beat 0 of a write: beat 1 must never reach the SRAM.
    @(negedge clk);
    wr_en = 1; address = 32'd1040; write_data = 32'h12345678;
    @(negedge clk);
    @(negedge clk);
    rst = 1; wr_en = 0;
    @(negedge clk);
    chk("abort_we_n", 64'(we_n), 64'(1));
    chk("abort_addr", 64'(sram_addr), 64'(0));
    chk("abort_read_data", 64'(read_data), 64'(0));
    chk("abort_ready", 64'(ready), 64'(1));
    rst = 0;
    repeat (4) @(negedge clk);
    chk("abort_idle_we_n", 64'(we_n), 64'(1));
    chk("abort_beat0_written", 64'(mem[8]), 64'(16'h5678));
    chk("abort_beat1_untouched", 64'(mem[9]), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
